// File: rtl/mem_access.sv
// Memory stage: turns execute-stage loads/stores into word-aligned req/gnt/rvalid
// bus transactions and forwards the raw load word plus instr/address to writeback.
module mem_access #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] rs2_data_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic [31:0] wb_instr_o,
    output logic [31:0] wb_alu_result_o,
    output logic [31:0] wb_data_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        misaligned_o,
    output logic        bus_err_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    // size = funct3[1:0]: 00 byte, 01 half, otherwise word
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (addr[0] == 1'b0);
            default: ok = (addr == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] addr);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << addr;
            2'b01:   be = addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] rs2);
        logic [31:0] wd;
        case (size)
            2'b00:   wd = {4{rs2[7:0]}};
            2'b01:   wd = {2{rs2[15:0]}};
            default: wd = rs2;
        endcase
        return wd;
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          wb_valid_q, wb_valid_d;
    logic [31:0]   wb_instr_q, wb_instr_d;
    logic [31:0]   wb_alu_q, wb_alu_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          mis_q, mis_d;
    logic          berr_q, berr_d;
    logic          stall_s;

    logic       is_load_s;
    logic       is_store_s;
    logic [1:0] size_s;
    logic       timeout_hit_s;

    assign is_load_s     = (instr_i[6:0] == OPC_LOAD);
    assign is_store_s    = (instr_i[6:0] == OPC_STORE);
    assign size_s        = instr_i[13:12];
    assign timeout_hit_s = (cnt_q >= CNT_LAST);

    // Next-state, latch and writeback-bundle logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        instr_d    = instr_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        wb_valid_d = 1'b0;
        wb_instr_d = wb_instr_q;
        wb_alu_d   = wb_alu_q;
        wb_data_d  = wb_data_q;
        mis_d      = 1'b0;
        berr_d     = 1'b0;
        stall_s    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid_i && (is_load_s || is_store_s)) begin
                    if (is_aligned(size_s, alu_result_i[1:0])) begin
                        instr_d = instr_i;
                        addr_d  = alu_result_i;
                        we_d    = is_store_s;
                        be_d    = is_store_s ? store_be(size_s, alu_result_i[1:0]) : 4'b1111;
                        wdata_d = is_store_s ? store_wdata(size_s, rs2_data_i) : 32'h0000_0000;
                        cnt_d   = {CW{1'b0}};
                        state_d = S_REQ;
                    end else begin
                        mis_d = 1'b1;
                    end
                end else if (valid_i) begin
                    wb_valid_d = 1'b1;
                    wb_instr_d = instr_i;
                    wb_alu_d   = alu_result_i;
                    wb_data_d  = 32'h0000_0000;
                end else begin
                    wb_valid_d = 1'b0;
                end
            end
            S_REQ: begin
                if (dmem_gnt_i && (we_q || dmem_rvalid_i)) begin
                    wb_valid_d = 1'b1;
                    wb_instr_d = instr_q;
                    wb_alu_d   = addr_q;
                    wb_data_d  = we_q ? 32'h0000_0000 : dmem_rdata_i;
                    state_d    = S_IDLE;
                end else if (timeout_hit_s) begin
                    berr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    stall_s = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = dmem_gnt_i ? S_WAIT : S_REQ;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    wb_valid_d = 1'b1;
                    wb_instr_d = instr_q;
                    wb_alu_d   = addr_q;
                    wb_data_d  = dmem_rdata_i;
                    state_d    = S_IDLE;
                end else if (timeout_hit_s) begin
                    berr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    stall_s = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, access latch and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CW{1'b0}};
            instr_q    <= 32'h0000_0000;
            addr_q     <= 32'h0000_0000;
            be_q       <= 4'b0000;
            wdata_q    <= 32'h0000_0000;
            we_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_instr_q <= 32'h0000_0000;
            wb_alu_q   <= 32'h0000_0000;
            wb_data_q  <= 32'h0000_0000;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            instr_q    <= instr_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            wb_valid_q <= wb_valid_d;
            wb_instr_q <= wb_instr_d;
            wb_alu_q   <= wb_alu_d;
            wb_data_q  <= wb_data_d;
            mis_q      <= mis_d;
            berr_q     <= berr_d;
        end
    end

    // req comes straight from the state flop so reset removes it asynchronously
    assign dmem_req_o      = (state_q == S_REQ);
    assign dmem_we_o       = we_q;
    assign dmem_addr_o     = {addr_q[31:2], 2'b00};
    assign dmem_be_o       = be_q;
    assign dmem_wdata_o    = wdata_q;
    assign stall_o         = stall_s;
    assign wb_valid_o      = wb_valid_q;
    assign wb_instr_o      = wb_instr_q;
    assign wb_alu_result_o = wb_alu_q;
    assign wb_data_o       = wb_data_q;
    assign misaligned_o    = mis_q;
    assign bus_err_o       = berr_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: stores, loads, streaming, misalignment, timeout
// and reset during an outstanding access.
module tb_mem_access;

    localparam int unsigned TO = 6;
    localparam logic [31:0] I_ADD  = 32'h0000_0033;
    localparam logic [31:0] I_ADD2 = 32'h0010_0033;
    localparam logic [31:0] I_LH   = 32'h0000_1003;
    localparam logic [31:0] I_LW   = 32'h0000_2003;
    localparam logic [31:0] I_SB   = 32'h0000_0023;
    localparam logic [31:0] I_SH   = 32'h0000_1023;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] instr_i = 32'h0;
    logic [31:0] alu_result_i = 32'h0;
    logic [31:0] rs2_data_i = 32'h0;
    logic        stall_o, wb_valid_o, dmem_req_o, dmem_we_o, misaligned_o, bus_err_o;
    logic [31:0] wb_instr_o, wb_alu_result_o, wb_data_o, dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = 32'h0;

    int tests = 0;
    int fails = 0;

    mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_i(valid_i), .instr_i(instr_i), .alu_result_i(alu_result_i),
        .rs2_data_i(rs2_data_i), .stall_o(stall_o),
        .wb_valid_o(wb_valid_o), .wb_instr_o(wb_instr_o),
        .wb_alu_result_o(wb_alu_result_o), .wb_data_o(wb_data_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance past the next rising edge, then let inputs be changed
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] alu,
                         input logic [31:0] rs2);
        valid_i = v; instr_i = ins; alu_result_i = alu; rs2_data_i = rs2;
    endtask

    task automatic bus(input logic g, input logic rv, input logic [31:0] rd);
        dmem_gnt_i = g; dmem_rvalid_i = rv; dmem_rdata_i = rd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, dmem_req_o, 1'b0);
        chk({tag, "_stall"}, stall_o, 1'b0);
        chk({tag, "_wbv"}, wb_valid_o, 1'b0);
        chk({tag, "_wbd"}, wb_data_o, 32'h0);
        chk({tag, "_we"}, dmem_we_o, 1'b0);
        chk({tag, "_be"}, dmem_be_o, 4'h0);
        chk({tag, "_addr"}, dmem_addr_o, 32'h0);
        chk({tag, "_mis"}, misaligned_o, 1'b0);
        chk({tag, "_berr"}, bus_err_o, 1'b0);
    endtask

    initial begin
        #2;
        chk_all_zero("rst");
        tick();
        rst_n = 1'b1;
        tick();

        // SB at 0x1003
        drive(1'b1, I_SB, 32'h0000_1003, 32'h0000_00A5); #1;
        chk("sb_accept_stall", stall_o, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0); #1;
        chk("sb_req", dmem_req_o, 1'b1);
        chk("sb_addr", dmem_addr_o, 32'h0000_1000);
        chk("sb_be", dmem_be_o, 4'b1000);
        chk("sb_wdata", dmem_wdata_o, 32'hA5A5_A5A5);
        chk("sb_we", dmem_we_o, 1'b1);
        chk("sb_stall_nognt", stall_o, 1'b1);
        chk("sb_wbv_during", wb_valid_o, 1'b0);
        bus(1'b1, 1'b0, 32'h0); #1;
        chk("sb_stall_gnt", stall_o, 1'b0);
        tick();
        bus(1'b0, 1'b0, 32'h0); #1;
        chk("sb_wbv", wb_valid_o, 1'b1);
        chk("sb_wbi", wb_instr_o, I_SB);
        chk("sb_wba", wb_alu_result_o, 32'h0000_1003);
        chk("sb_wbd", wb_data_o, 32'h0);
        chk("sb_req_done", dmem_req_o, 1'b0);
        tick(); #1;
        chk("sb_wbv_once", wb_valid_o, 1'b0);

        // SH at 0x0002: upper half lanes
        drive(1'b1, I_SH, 32'h0000_0002, 32'h1234_ABCD);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0); #1;
        chk("sh_be", dmem_be_o, 4'b1100);
        chk("sh_wdata", dmem_wdata_o, 32'hABCD_ABCD);
        bus(1'b1, 1'b0, 32'h0);
        tick();
        bus(1'b0, 1'b0, 32'h0);
        tick();

        // LW at 0x2000: gnt in 3rd REQ cycle, rvalid two cycles after gnt
        drive(1'b1, I_LW, 32'h0000_2000, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            bus(c == 2, 1'b0, 32'h0); #1;
            chk($sformatf("lw_req%0d", c), dmem_req_o, 1'b1);
            chk($sformatf("lw_addr%0d", c), dmem_addr_o, 32'h0000_2000);
            chk($sformatf("lw_be%0d", c), dmem_be_o, 4'b1111);
            chk($sformatf("lw_we%0d", c), dmem_we_o, 1'b0);
            chk($sformatf("lw_stall%0d", c), stall_o, 1'b1);
            tick();
        end
        bus(1'b0, 1'b0, 32'h0); #1;
        chk("lw_wait_req", dmem_req_o, 1'b0);
        chk("lw_wait_stall", stall_o, 1'b1);
        tick();
        bus(1'b0, 1'b1, 32'hDEAD_BEEF); #1;
        chk("lw_rv_stall", stall_o, 1'b0);
        tick();
        bus(1'b0, 1'b0, 32'h0); #1;
        chk("lw_wbv", wb_valid_o, 1'b1);
        chk("lw_wbd", wb_data_o, 32'hDEAD_BEEF);
        chk("lw_wba", wb_alu_result_o, 32'h0000_2000);
        chk("lw_wbi", wb_instr_o, I_LW);

        // stream ADD, LH@0x12, ADD2 with same-cycle gnt+rvalid
        drive(1'b1, I_ADD, 32'h0000_0011, 32'h0);
        tick();
        #1;
        chk("st_add_wbv", wb_valid_o, 1'b1);
        chk("st_add_wbi", wb_instr_o, I_ADD);
        chk("st_add_wbd", wb_data_o, 32'h0);
        drive(1'b1, I_LH, 32'h0000_0012, 32'h0); #1;
        chk("st_lh_acc_stall", stall_o, 1'b0);
        tick();
        drive(1'b1, I_ADD2, 32'h0000_0022, 32'h0);
        bus(1'b1, 1'b1, 32'h0000_BEEF); #1;
        chk("st_lh_req", dmem_req_o, 1'b1);
        chk("st_lh_wbv_busy", wb_valid_o, 1'b0);
        chk("st_lh_stall", stall_o, 1'b0);
        tick();
        bus(1'b0, 1'b0, 32'h0); #1;
        chk("st_lh_wbv", wb_valid_o, 1'b1);
        chk("st_lh_wbi", wb_instr_o, I_LH);
        chk("st_lh_wbd", wb_data_o, 32'h0000_BEEF);
        chk("st_add2_acc_stall", stall_o, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0); #1;
        chk("st_add2_wbv", wb_valid_o, 1'b1);
        chk("st_add2_wbi", wb_instr_o, I_ADD2);
        chk("st_add2_wba", wb_alu_result_o, 32'h0000_0022);
        chk("st_add2_wbd", wb_data_o, 32'h0);
        tick(); #1;
        chk("st_no_dup", wb_valid_o, 1'b0);

        // misaligned LW 0x3002 then SH 0x3001
        drive(1'b1, I_LW, 32'h0000_3002, 32'h0);
        tick();
        drive(1'b1, I_SH, 32'h0000_3001, 32'h0); #1;
        chk("mis_lw_pulse", misaligned_o, 1'b1);
        chk("mis_lw_req", dmem_req_o, 1'b0);
        chk("mis_lw_wbv", wb_valid_o, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0); #1;
        chk("mis_sh_pulse", misaligned_o, 1'b1);
        chk("mis_sh_req", dmem_req_o, 1'b0);
        chk("mis_sh_wbv", wb_valid_o, 1'b0);
        tick(); #1;
        chk("mis_clear", misaligned_o, 1'b0);

        // timeout: gnt never arrives
        drive(1'b1, I_LW, 32'h0000_5000, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        for (int c = 0; c < TO; c++) begin
            #1;
            chk($sformatf("to_req%0d", c), dmem_req_o, 1'b1);
            chk($sformatf("to_stall%0d", c), stall_o, (c == TO - 1) ? 1'b0 : 1'b1);
            chk($sformatf("to_berr%0d", c), bus_err_o, 1'b0);
            tick();
        end
        #1;
        chk("to_berr", bus_err_o, 1'b1);
        chk("to_req_off", dmem_req_o, 1'b0);
        chk("to_wbv", wb_valid_o, 1'b0);
        drive(1'b1, I_ADD, 32'h0000_0077, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0); #1;
        chk("to_berr_once", bus_err_o, 1'b0);
        chk("to_add_wbv", wb_valid_o, 1'b1);
        chk("to_add_wba", wb_alu_result_o, 32'h0000_0077);

        // reset while in REQ: req drops immediately
        drive(1'b1, I_LW, 32'h0000_4000, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0); #1;
        chk("rq_req", dmem_req_o, 1'b1);
        rst_n = 1'b0; #1;
        chk("rq_req_async", dmem_req_o, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // reset while in WAIT, rvalid afterwards is ignored
        drive(1'b1, I_LW, 32'h0000_4000, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        bus(1'b1, 1'b0, 32'h0);
        tick();
        bus(1'b0, 1'b0, 32'h0); #1;
        chk("rw_wait_stall", stall_o, 1'b1);
        rst_n = 1'b0; #1;
        chk_all_zero("rw");
        tick();
        rst_n = 1'b1;
        bus(1'b0, 1'b1, 32'hCAFE_F00D);
        tick();
        bus(1'b0, 1'b0, 32'h0); #1;
        chk("rw_ign_wbv", wb_valid_o, 1'b0);
        chk("rw_ign_wbd", wb_data_o, 32'h0);
        chk("rw_ign_stall", stall_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
